// File: rtl/sram_row_ctrl_pkg.sv
// Shared definitions for the SRAM row-fill controller: FSM states and
// the SRAM command encodings.
package sram_row_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic SRAM_READ  = 1'b1;
  localparam logic SRAM_WRITE = 1'b0;
  localparam logic SRC_SDRAM  = 1'b1;
  localparam logic SRC_WB     = 1'b0;

endpackage

// File: rtl/sram_row_ctrl_fifo2.sv
// Two-entry output FIFO between the SRAM read return and the window buffer.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module row_ctrl_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign valid   = (count != 2'd0);
  assign do_pop  = pop && valid;
  assign do_push = push && ((count != 2'd2) || do_pop);
  // Stale storage is never exposed while the FIFO is empty.
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sram_row_ctrl.sv
// Fills one SRAM image row from the SDRAM word stream, then drains it back
// out to the window buffer in address order; alternates between two rows.
module sram_row_ctrl
  import sram_row_ctrl_pkg::*;
#(
  parameter int ROW_LEN = 640,
  parameter int ADDR_W  = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       sd_data,
  input  logic              sd_valid,
  output logic              sd_ready,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_mode,
  output logic              sram_addr_calc_mode,
  output logic              sram_enable,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_read_valid,
  output logic [31:0]       px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              busy,
  output logic              row_done,
  output logic              row_sel
);

  localparam int CW = $clog2(ROW_LEN + 1);
  localparam logic [CW-1:0] LEN  = CW'(ROW_LEN);
  localparam logic [CW-1:0] LAST = CW'(ROW_LEN - 1);

  state_t            state;
  logic [CW-1:0]     wr_cnt;
  logic [CW-1:0]     rd_cnt;
  logic [CW-1:0]     pop_cnt;
  logic              pending;
  logic              busy_q;
  logic              ready_q;
  logic              done_q;
  logic              sel_q;
  logic              accept;
  logic              issue;
  logic              pop;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] row_base;
  logic              fifo_valid;
  logic [31:0]       fifo_head;
  logic [1:0]        fifo_count;
  logic              unused_read_valid;

  // Read returns are tracked by the pending flag, so the SRAM's own strobe is not needed.
  assign unused_read_valid = sram_read_valid;

  assign row_base = sel_q ? ADDR_W'(ROW_LEN) : '0;
  assign accept   = !rst && ready_q && sd_valid;
  assign pop      = !rst && fifo_valid && px_ready;
  // Counting the same-cycle pop lets the drain sustain one word per cycle.
  assign occ      = {1'b0, fifo_count} + {2'b0, pending} - {2'b0, pop};
  assign issue    = !rst && (state == DRAIN) && (rd_cnt < LEN) && (occ < 3'd2);

  row_ctrl_fifo2 #(.W(32)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pending),
    .push_data (sram_rdata),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      pop_cnt <= '0;
      pending <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      pending <= issue;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= FILL;
            busy_q  <= 1'b1;
            ready_q <= 1'b1;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            pop_cnt <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST) begin
              state   <= DRAIN;
              ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (issue) rd_cnt <= rd_cnt + 1'b1;
          if (pop) begin
            pop_cnt <= pop_cnt + 1'b1;
            if (pop_cnt == LAST) begin
              state  <= DONE;
              done_q <= 1'b1;
            end
          end
        end
        DONE: begin
          sel_q  <= ~sel_q;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low for the whole time reset is held.
  assign sd_ready            = ready_q && !rst;
  assign busy                = busy_q && !rst;
  assign row_done            = done_q && !rst;
  assign row_sel             = sel_q && !rst;
  assign px_valid            = fifo_valid && !rst;
  assign px_data             = rst ? '0 : fifo_head;
  assign sram_enable         = accept || issue;
  assign sram_mode           = issue ? SRAM_READ : SRAM_WRITE;
  assign sram_addr_calc_mode = accept ? SRC_SDRAM : SRC_WB;
  assign sram_wdata          = accept ? sd_data : '0;
  assign sram_address        = accept ? (row_base + ADDR_W'(wr_cnt)) :
                               issue  ? (row_base + ADDR_W'(rd_cnt)) : '0;

endmodule

// File: tb/tb_sram_row_ctrl.sv
// Scoreboard bench for sram_row_ctrl with ROW_LEN=4: fills and drains rows,
// exercises backpressure, ignored starts, sd_valid gaps and mid-drain reset.
module tb_sram_row_ctrl;

  localparam int ROW_LEN = 4;
  localparam int ADDR_W  = 26;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [31:0]       sd_data = '0;
  logic              sd_valid = 1'b0;
  logic              sd_ready;
  logic [ADDR_W-1:0] sram_address;
  logic              sram_mode;
  logic              sram_addr_calc_mode;
  logic              sram_enable;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata = '0;
  logic              sram_read_valid = 1'b0;
  logic [31:0]       px_data;
  logic              px_valid;
  logic              px_ready = 1'b1;
  logic              busy;
  logic              row_done;
  logic              row_sel;

  int tests = 0;
  int failures = 0;
  int cyc = 0;
  int px_mode = 0;
  int row_writes = 0;
  int row_reads = 0;
  int row_pops = 0;
  int outstanding = 0;
  int first_rd = 0;
  int last_pop = 0;
  int done_cyc = 0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  logic [59:0] wr_q [$];
  logic [27:0] rd_q [$];
  logic [31:0] px_q [$];
  logic [31:0] sram_mem [16];

  sram_row_ctrl #(.ROW_LEN(ROW_LEN), .ADDR_W(ADDR_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .sd_data             (sd_data),
    .sd_valid            (sd_valid),
    .sd_ready            (sd_ready),
    .sram_address        (sram_address),
    .sram_mode           (sram_mode),
    .sram_addr_calc_mode (sram_addr_calc_mode),
    .sram_enable         (sram_enable),
    .sram_wdata          (sram_wdata),
    .sram_rdata          (sram_rdata),
    .sram_read_valid     (sram_read_valid),
    .px_data             (px_data),
    .px_valid            (px_valid),
    .px_ready            (px_ready),
    .busy                (busy),
    .row_done            (row_done),
    .row_sel             (row_sel)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model with one cycle of read latency.
  always @(posedge clk) begin
    sram_read_valid <= 1'b0;
    if (sram_enable) begin
      if (sram_mode) begin
        sram_rdata      <= sram_mem[sram_address[3:0]];
        sram_read_valid <= 1'b1;
      end else begin
        sram_mem[sram_address[3:0]] <= sram_wdata;
      end
    end
  end

  // Window-buffer side ready: steady or toggling every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (px_mode == 1) px_ready = ~px_ready;
      else px_ready = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: compare every SRAM command and every pixel pop against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("px_hold_valid", {63'd0, px_valid}, 64'd1);
        checkOutput("px_hold_data", {32'd0, px_data}, {32'd0, prev_data});
      end
      if (px_valid && px_ready) begin
        if (px_q.size() == 0) checkOutput("px_unexpected", 64'd1, 64'd0);
        else checkOutput("px_data", {32'd0, px_data}, {32'd0, px_q.pop_front()});
        if (px_mode == 0) begin
          if (row_pops == 0) checkOutput("first_px_latency", 64'(cyc - first_rd), 64'd2);
          else checkOutput("px_back_to_back", 64'(cyc - last_pop), 64'd1);
        end
        last_pop = cyc;
        row_pops++;
        outstanding--;
      end
      if (sram_enable && !sram_mode) begin
        if (wr_q.size() == 0) checkOutput("write_unexpected", 64'd1, 64'd0);
        else checkOutput("write", {4'd0, sram_addr_calc_mode, sram_mode, sram_address, sram_wdata},
                         {4'd0, wr_q.pop_front()});
        row_writes++;
      end
      if (sram_enable && sram_mode) begin
        if (rd_q.size() == 0) checkOutput("read_unexpected", 64'd1, 64'd0);
        else checkOutput("read", {36'd0, sram_addr_calc_mode, sram_mode, sram_address},
                         {36'd0, rd_q.pop_front()});
        if (row_reads == 0) first_rd = cyc;
        row_reads++;
        outstanding++;
        checkOutput("occupancy_le2", {63'd0, outstanding <= 2}, 64'd1);
      end
      if (!sram_enable)
        checkOutput("sram_idle", {3'd0, sram_addr_calc_mode, sram_mode, sram_address, sram_wdata}, 64'd0);
      if (row_done) done_cyc = cyc;
      prev_stall = px_valid && !px_ready;
      prev_data  = px_data;
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_sram"}, {3'd0, sram_enable, sram_mode, sram_addr_calc_mode, sram_address, sram_wdata}, 64'd0);
    checkOutput({tag, "_ctrl"}, {27'd0, sd_ready, px_valid, px_data, busy, row_done, row_sel}, 64'd0);
  endtask

  // Runs one row: start, fill ROW_LEN words, drain; optionally reset mid-drain.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [31:0] dbase,
                               input int mode, input bit gaps, input int reset_after,
                               input bit exp_sel);
    bit seen = 1'b0;
    bit glitched = 1'b0;
    row_writes = 0;
    row_reads = 0;
    row_pops = 0;
    outstanding = 0;
    for (int i = 0; i < ROW_LEN; i++) begin
      wr_q.push_back({1'b1, 1'b0, base + ADDR_W'(i), dbase + 32'(i)});
      rd_q.push_back({1'b0, 1'b1, base + ADDR_W'(i)});
      px_q.push_back(dbase + 32'(i));
    end
    px_mode = mode;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < ROW_LEN; i++) begin
      if (gaps && (i % 2 == 1)) begin
        sd_valid = 1'b0;
        sd_data  = 32'hDEAD_0000;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
      end
      sd_valid = 1'b1;
      sd_data  = dbase + 32'(i);
      @(negedge clk); #1;
      checkOutput("sd_ready_fill", {63'd0, sd_ready}, 64'd1);
      if (i == 0) checkOutput("busy_fill", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
    end
    sd_valid = 1'b0;
    sd_data  = '0;
    @(negedge clk); #1;
    checkOutput("sd_ready_off", {63'd0, sd_ready}, 64'd0);
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #1;
      start = gaps && (row_pops == 1) && !glitched;
      if (start) glitched = 1'b1;
      @(negedge clk); #1;
      if (reset_after > 0 && row_pops >= reset_after) begin
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk); #1;
        checkAllZero("rst_held");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        checkAllZero("rst_after");
        checkOutput("rst_pops", 64'(row_pops), 64'(reset_after));
        wr_q.delete();
        rd_q.delete();
        px_q.delete();
        outstanding = 0;
        @(posedge clk); #1;
        return;
      end
      if (row_done) seen = 1'b1;
    end
    start = 1'b0;
    checkOutput("row_done_seen", {63'd0, seen}, 64'd1);
    checkOutput("row_done_timing", 64'(done_cyc), 64'(last_pop + 1));
    @(negedge clk); #1;
    checkOutput("row_done_pulse", {63'd0, row_done}, 64'd0);
    checkOutput("row_sel", {63'd0, row_sel}, {63'd0, exp_sel});
    checkOutput("busy_idle", {63'd0, busy}, 64'd0);
    checkOutput("row_writes", 64'(row_writes), 64'(ROW_LEN));
    checkOutput("row_pops", 64'(row_pops), 64'(ROW_LEN));
    checkOutput("scoreboard_empty", 64'(wr_q.size() + rd_q.size() + px_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk); #1;
    checkAllZero("reset_held");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    checkAllZero("reset_after");
    @(posedge clk); #1;

    applyStimulus(26'd0, 32'hA0, 0, 1'b0, 0, 1'b1);
    applyStimulus(26'd4, 32'hB0, 1, 1'b1, 0, 1'b0);
    applyStimulus(26'd0, 32'hC0, 0, 1'b0, 0, 1'b1);
    applyStimulus(26'd4, 32'hD0, 0, 1'b0, 2, 1'b0);
    applyStimulus(26'd0, 32'hE0, 0, 1'b0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_row_ctrl.md
SRAM_ROW_CTRL -- requirements
Module: sram_row_ctrl

Interface
REQ-001 SHALL have parameter ROW_LEN, default 640, meaning 32-bit words per image row (range 2..8192).
REQ-002 SHALL have parameter ADDR_W, default 26, meaning SRAM address width.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a row fill.
REQ-006 SHALL have ports sd_data in 32, sd_valid in 1, sd_ready out 1, forming the SDRAM-buffer word stream.
REQ-007 SHALL have ports sram_address out ADDR_W, sram_mode out 1 (1 read, 0 write), sram_addr_calc_mode out 1 (1 selects SDRAM data), sram_enable out 1, sram_wdata out 32, driving the SRAM.
REQ-008 SHALL have ports sram_rdata in 32 and sram_read_valid in 1, carrying SRAM read returns.
REQ-009 SHALL have ports px_data out 32, px_valid out 1, px_ready in 1, forming the window-buffer word stream.
REQ-010 SHALL have ports busy out 1, row_done out 1 (one-cycle pulse) and row_sel out 1 (row currently being filled).

Function
REQ-011 SHALL implement FSM states IDLE, FILL, DRAIN and DONE.
REQ-012 IDLE -> FILL on start; start is ignored in any other state; busy SHALL be 1 in every state except IDLE.
REQ-013 SHALL assert sd_ready only in FILL; a word is accepted when sd_valid and sd_ready are both 1.
REQ-014 On each accepted word, in the same cycle, SHALL drive sram_enable=1, sram_mode=0, sram_addr_calc_mode=1, sram_wdata=sd_data and sram_address=row_base+wr_cnt, where row_base=row_sel*ROW_LEN.
REQ-015 SHALL drive sram_enable=0 in any cycle with no accepted write or issued read; in idle cycles sram_address, sram_mode and sram_addr_calc_mode SHALL hold 0.
REQ-016 FILL -> DRAIN on the cycle the ROW_LEN-th word is accepted; sd_ready SHALL be 0 from the next cycle.
REQ-017 In DRAIN, SHALL issue a read (sram_enable=1, sram_mode=1, address row_base+rd_cnt) only when rd_cnt<ROW_LEN and output-buffer occupancy plus in-flight reads is less than 2.
REQ-018 Read latency SHALL be 1: data issued in cycle t is captured from sram_rdata in cycle t+1 into a 2-entry output FIFO, using an internal pending flag rather than sram_read_valid.
REQ-019 px_valid SHALL be FIFO not-empty and px_data SHALL be the FIFO head; the head pops when px_valid and px_ready are both 1; order SHALL be address order.
REQ-020 With px_ready held at 1, DRAIN SHALL sustain one word per cycle after the first-word latency of 2 cycles.
REQ-021 A push and a pop in the same cycle on a full FIFO SHALL be legal and keep occupancy unchanged.
REQ-022 DRAIN -> DONE when the ROW_LEN-th word pops; DONE SHALL pulse row_done for 1 cycle, toggle row_sel and return to IDLE.
REQ-023 Counters SHALL be ceil(log2(ROW_LEN+1)) bits wide and never wrap; row_base SHALL be computed at ADDR_W width without truncation.
REQ-024 px_valid SHALL never drop while px_ready=0, and px_data SHALL be stable while px_valid=1 and px_ready=0.

Reset
REQ-025 On rst, regardless of state, SHALL go to IDLE with counters at 0, FIFO empty, pending flag at 0 and row_sel at 0.
REQ-026 While rst is asserted, and in the cycle after it, all outputs SHALL be 0 (including sd_ready, sram_enable, px_valid, busy and row_done).
REQ-027 A read returning after rst SHALL be discarded.

Structure
REQ-028 A shared package SHALL hold the FSM state enum, SRAM_READ=1 and SRAM_WRITE=0, and the SRC_SDRAM=1 and SRC_WB=0 constants.
REQ-029 The 2-entry output FIFO SHALL be a sub-module named row_ctrl_fifo2.

Verification
REQ-030 With ROW_LEN=4: start, then 4 words 0xA0..0xA3 with sd_valid held 1 -> writes to addresses 0..3 on consecutive cycles, then sd_ready=0.
REQ-031 After REQ-030, with px_ready=1 -> px_data sequence 0xA0..0xA3 on 4 consecutive cycles starting 2 cycles after the first read, then a row_done pulse and row_sel=1.
REQ-032 On a second row, px_ready toggling 1/0 -> no loss or duplication, reads use addresses 4..7, and FIFO occupancy stays at or below 2.
REQ-033 Assert rst during DRAIN after 2 words -> next cycle IDLE with all outputs 0; a new start fills addresses 0..3.
REQ-034 Pulse start while busy, and toggle sd_valid with gaps -> start has no effect; exactly ROW_LEN writes occur with no write in gap cycles.
